uart_init_seq: RTL and testbench
================================

Name: uart_init_seq

Overview:
- AXI4-Lite master that brings up the UART after reset or on software request.
- Sequence: write baud divisor, write control word, read control back and compare.
- Sits between the system reset/boot controller and the uart_wrapper AXI4-Lite slave port. It is the sole configuration master for the UART during init.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (32 only).
- BASE_OFFSET, 64'h0, UART base address; the low ADDR_WIDTH bits are used.
- BAUD_OFFSET, 'h10, byte offset of the baud divisor register.
- CTRL_OFFSET, 'h14, byte offset of the control register.
- CTRL_RB_MASK, 32'hFFFF_FFFF, bits compared on control readback.
- TIMEOUT_CYC, 1024, maximum cycles to wait for any single handshake or response; range 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin sequence; sampled only in IDLE
- baud_div  in  32  divisor, latched on accepted start
- ctrl_word  in  32  control value, latched on accepted start
- busy  out  1  high from accepted start until DONE/ERR is entered
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky failure flag, cleared on next accepted start
- err_code  out  2  0 none, 1 SLVERR/DECERR, 2 readback mismatch, 3 timeout
- m_awaddr  out  ADDR_WIDTH  write address
- m_awvalid  out  1  write address valid
- m_awready  in  1  write address ready
- m_wdata  out  32  write data
- m_wstrb  out  4  always 4'hF
- m_wvalid  out  1  write data valid
- m_wready  in  1  write data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready
- m_araddr  out  ADDR_WIDTH  read address
- m_arvalid  out  1  read address valid
- m_arready  in  1  read address ready
- m_rdata  in  32  read data
- m_rresp  in  2  read response
- m_rvalid  in  1  read data valid
- m_rready  out  1  read data ready

Behaviour:
- Reset state: state IDLE, timer 0.
- Outputs held low during reset: all valids, bready, rready, busy, done, err.
- Reset values of other outputs: err_code 0, m_awaddr/m_araddr/m_wdata 0, m_wstrb 4'hF.
- Reset asserted mid-sequence: all valids drop immediately (asynchronous). No transaction is completed or retried after release.
- States: IDLE → WR_BAUD → B_BAUD → WR_CTRL → B_CTRL → RD_CTRL → R_CTRL → IDLE. Any failure goes to ERR, then IDLE.
- IDLE: start=1 latches inputs, clears err/err_code, sets busy, and moves to WR_BAUD on the next edge.
- IDLE: start while busy is impossible. A start pulse outside IDLE is ignored.
- WR_x: awvalid and wvalid assert in the same cycle. Each drops independently after its own ready handshake.
- WR_x exits to B_x once both handshakes are done, including both in the same cycle or in either order.
- Valids never drop before their handshake. Address, data and strobe stay stable while valid.
- WR_BAUD address is BASE_OFFSET+BAUD_OFFSET with data baud_div. WR_CTRL uses CTRL_OFFSET with data ctrl_word.
- B_x: bready=1. On bvalid, bresp==0 advances; a nonzero bresp goes to ERR with code 1.
- RD_CTRL: arvalid until arready, address BASE_OFFSET+CTRL_OFFSET.
- R_CTRL: rready=1. On rvalid:
  - rresp≠0 → ERR, code 1.
  - (rdata ^ ctrl_word) & CTRL_RB_MASK ≠ 0 → ERR, code 2.
  - Otherwise pulse done for 1 cycle and clear busy as IDLE is re-entered.
- Timer: cleared on every state change, increments each cycle in non-IDLE states. Reaching TIMEOUT_CYC goes to ERR with code 3 and deasserts all valids/readies.
- A timeout abandons the AXI transaction. Software must reset the slave before retry.
- ERR: sets err and holds err_code, clears busy, returns to IDLE next cycle. done is not pulsed.
- Minimum latency with zero-wait slave, start edge to done pulse: 7 cycles (one per state, 2 for the read path).

Test Plan:
- Zero-wait OKAY slave, baud_div=32'h0000_0036, ctrl_word=32'h3, readback 3:
  - expect AW 'h10/W 'h36, then AW 'h14/W 'h3, then AR 'h14.
  - expect done 7 cycles after start; busy high 6 cycles; err=0.
- Slave with awready 3 cycles before wready, then wready 2 cycles before awready:
  - expect each valid held exactly until its own handshake;
  - expect no duplicate beat; sequence completes.
- bresp=2'b10 on the baud write: expect no AW for CTRL, err=1, err_code=1, busy falls, no done.
- Readback 32'h7 with ctrl_word 32'h3:
  - CTRL_RB_MASK all ones → err_code=2.
  - CTRL_RB_MASK=32'h3 → done, err=0.
- TIMEOUT_CYC=16, arready never asserted: expect arvalid drops after 16 cycles, err_code=3. A following start clears err and completes.
- rst asserted in B_CTRL: expect outputs low immediately and IDLE after release. Start pulse during busy is ignored; only one sequence is observed.

Source files
------------

// File: rtl/uart_init_seq.sv
// AXI4-Lite configuration master that brings up the UART: writes the baud divisor,
// writes the control word, then reads control back and compares it under a mask.
module uart_init_seq #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [63:0]           BASE_OFFSET  = 64'h0,
  parameter logic [63:0]           BAUD_OFFSET  = 64'h10,
  parameter logic [63:0]           CTRL_OFFSET  = 64'h14,
  parameter logic [DATA_WIDTH-1:0] CTRL_RB_MASK = 32'hFFFF_FFFF,
  parameter int unsigned           TIMEOUT_CYC  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     baud_div,
  input  logic [DATA_WIDTH-1:0]     ctrl_word,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  // A beat transfers on the rising edge where valid and ready are both high; a valid,
  // once raised, holds its address/data stable until that edge (or a timeout/reset).

  localparam logic [63:0]           BAUD_SUM   = BASE_OFFSET + BAUD_OFFSET;
  localparam logic [63:0]           CTRL_SUM   = BASE_OFFSET + CTRL_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] BAUD_ADDR  = BAUD_SUM[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = CTRL_SUM[ADDR_WIDTH-1:0];
  localparam logic [15:0]           TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BAUD, S_B_BAUD, S_WR_CTRL, S_B_CTRL, S_RD_CTRL, S_R_CTRL, S_ERR
  } state_t;

  state_t                state, state_n;
  logic [15:0]           timer;
  logic                  aw_done, w_done;
  logic                  aw_hs, w_hs, wr_both, timer_hit, seq_ok;
  logic [1:0]            fail_code;
  logic [DATA_WIDTH-1:0] ctrl_q;

  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign wr_both   = (aw_done || aw_hs) && (w_done || w_hs);
  assign timer_hit = (timer == TIMER_LAST);

  // Valids/readies decode straight from state so an asynchronous reset drops them at once.
  assign m_awvalid = ((state == S_WR_BAUD) || (state == S_WR_CTRL)) && !aw_done;
  assign m_wvalid  = ((state == S_WR_BAUD) || (state == S_WR_CTRL)) && !w_done;
  assign m_bready  = (state == S_B_BAUD) || (state == S_B_CTRL);
  assign m_arvalid = (state == S_RD_CTRL);
  assign m_rready  = (state == S_R_CTRL);
  assign m_wstrb   = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fail_code = 2'd0;
    seq_ok    = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_WR_BAUD;
      S_WR_BAUD, S_WR_CTRL: begin
        if (wr_both) state_n = (state == S_WR_BAUD) ? S_B_BAUD : S_B_CTRL;
        else if (timer_hit) begin
          state_n   = S_ERR;
          fail_code = 2'd3;
        end
      end
      S_B_BAUD, S_B_CTRL: begin
        if (m_bvalid) begin
          if (m_bresp == 2'b00) state_n = (state == S_B_BAUD) ? S_WR_CTRL : S_RD_CTRL;
          else begin
            state_n   = S_ERR;
            fail_code = 2'd1;
          end
        end else if (timer_hit) begin
          state_n   = S_ERR;
          fail_code = 2'd3;
        end
      end
      S_RD_CTRL: begin
        if (m_arready) state_n = S_R_CTRL;
        else if (timer_hit) begin
          state_n   = S_ERR;
          fail_code = 2'd3;
        end
      end
      S_R_CTRL: begin
        if (m_rvalid) begin
          if (m_rresp != 2'b00) begin
            state_n   = S_ERR;
            fail_code = 2'd1;
          end else if (((m_rdata ^ ctrl_q) & CTRL_RB_MASK) != '0) begin
            state_n   = S_ERR;
            fail_code = 2'd2;
          end else begin
            state_n = S_IDLE;
            seq_ok  = 1'b1;
          end
        end else if (timer_hit) begin
          state_n   = S_ERR;
          fail_code = 2'd3;
        end
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      m_awaddr <= '0;
      m_araddr <= '0;
      m_wdata  <= '0;
      ctrl_q   <= '0;
    end else begin
      done <= seq_ok;
      if (state_n != state) begin
        timer   <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (state != S_IDLE) timer <= timer + 16'd1;
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      // Bus address/data are loaded one state ahead so they are stable when valid rises.
      case (state)
        S_IDLE: if (start) begin
          busy     <= 1'b1;
          err      <= 1'b0;
          err_code <= 2'd0;
          ctrl_q   <= ctrl_word;
          m_awaddr <= BAUD_ADDR;
          m_wdata  <= baud_div;
        end
        S_B_BAUD: if (state_n == S_WR_CTRL) begin
          m_awaddr <= CTRL_ADDR;
          m_wdata  <= ctrl_q;
        end
        S_B_CTRL: if (state_n == S_RD_CTRL) m_araddr <= CTRL_ADDR;
        default: ;
      endcase
      if (state_n == S_ERR) begin
        err      <= 1'b1;
        err_code <= fail_code;
        busy     <= 1'b0;
      end
      if (seq_ok) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_init_seq.sv
// Testbench for uart_init_seq: cycle-driven AXI4-Lite slave, transaction logs and a
// transaction-level reference model; a second instance uses a narrow readback mask.
module tb_uart_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] baud_div = '0, ctrl_word = '0;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = '0, m_rresp = '0;
  logic [31:0] m_rdata = '0;

  logic        busy0, done0, err0;
  logic [1:0]  code0;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  logic        busy1, done1, err1;
  logic [1:0]  code1;
  logic [31:0] awaddr1, wdata1, araddr1;
  logic [3:0]  wstrb1;
  logic        awvalid1, wvalid1, bready1, arvalid1, rready1;

  localparam logic [31:0] BAUD_A = 32'h10;
  localparam logic [31:0] CTRL_A = 32'h14;
  localparam logic [31:0] MASK1  = 32'h3;

  uart_init_seq #(.TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .baud_div(baud_div), .ctrl_word(ctrl_word),
    .busy(busy0), .done(done0), .err(err0), .err_code(code0),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Shares the slave with u_dut; it follows the same bus traffic and differs only in readback.
  uart_init_seq #(.TIMEOUT_CYC(16), .CTRL_RB_MASK(MASK1)) u_dut_m (
    .clk(clk), .rst(rst), .start(start), .baud_div(baud_div), .ctrl_word(ctrl_word),
    .busy(busy1), .done(done1), .err(err1), .err_code(code1),
    .m_awaddr(awaddr1), .m_awvalid(awvalid1), .m_awready(m_awready),
    .m_wdata(wdata1), .m_wstrb(wstrb1), .m_wvalid(wvalid1), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(bready1),
    .m_araddr(araddr1), .m_arvalid(arvalid1), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(rready1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Slave behaviour for the next sequence.
  int          aw_lat[2], w_lat[2];
  int          b_lat, r_lat, restart_at;
  bit          ar_never, rst_in_bctrl;
  logic [1:0]  bresp_cfg[2];
  logic [1:0]  rresp_cfg;
  logic [31:0] rdata_cfg;

  // Observations of the last sequence.
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int          aw_hold[$], w_hold[$];
  int          done_cnt, done1_cnt, done_lat, busy_cnt, arv_cnt, viol;
  bit          seq_to, err_first;
  logic [8:0]  rst_snap;

  // Scoreboard expectations.
  logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$];

  task automatic default_cfg();
    aw_lat = '{0, 0}; w_lat = '{0, 0};
    b_lat = 0; r_lat = 0; restart_at = -1;
    ar_never = 1'b0; rst_in_bctrl = 1'b0;
    bresp_cfg = '{2'b00, 2'b00};
    rresp_cfg = 2'b00; rdata_cfg = '0;
  endtask

  // Expected bus traffic: each write only happens if every earlier write got OKAY.
  task automatic fill_model(input logic [31:0] baud, input logic [31:0] ctrl);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    exp_aw_q.push_back(BAUD_A); exp_w_q.push_back(baud);
    if (bresp_cfg[0] == 2'b00) begin
      exp_aw_q.push_back(CTRL_A); exp_w_q.push_back(ctrl);
      if (bresp_cfg[1] == 2'b00) exp_ar_q.push_back(CTRL_A);
    end
  endtask

  function automatic logic [1:0] model_code(input logic [31:0] ctrl, input logic [31:0] mask);
    if (bresp_cfg[0] != 2'b00 || bresp_cfg[1] != 2'b00) return 2'd1;
    if (ar_never) return 2'd3;
    if (rresp_cfg != 2'b00) return 2'd1;
    if (((rdata_cfg ^ ctrl) & mask) != 32'h0) return 2'd2;
    return 2'd0;
  endfunction

  // Runs one start-triggered sequence, acting as the slave on every falling edge.
  task automatic run_seq(input logic [31:0] baud, input logic [31:0] ctrl);
    int   aw_wait, w_wait, b_wait, r_wait, quiet, wr_idx, wi, rst_c;
    bit   aw_got, w_got, b_pend, r_pend, fin, rst_used;
    logic s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    aw_log.delete(); w_log.delete(); ar_log.delete(); aw_hold.delete(); w_hold.delete();
    done_cnt = 0; done1_cnt = 0; done_lat = -1; busy_cnt = 0; arv_cnt = 0; viol = 0;
    seq_to = 1'b0; err_first = 1'b1; rst_snap = '1;
    aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0; quiet = 0; wr_idx = 0; rst_c = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; fin = 0; rst_used = 0;
    {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0;
    @(negedge clk);
    baud_div = baud; ctrl_word = ctrl; start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = (c + 1 == restart_at);
      if (rst && c >= rst_c + 3) rst = 1'b0;
      // Resolve the beats that transferred on the last rising edge.
      if (s_awv && s_awr) begin
        aw_log.push_back(s_awaddr); aw_hold.push_back(aw_wait); aw_wait = 0; aw_got = 1;
        if (m_awvalid) viol++;
      end else if (s_awv) begin
        if (!m_awvalid && !err0 && !rst) viol++;
        else if (m_awvalid && m_awaddr !== s_awaddr) viol++;
      end
      if (s_wv && s_wr) begin
        w_log.push_back(s_wdata); w_hold.push_back(w_wait); w_wait = 0; w_got = 1;
        if (m_wvalid) viol++;
      end else if (s_wv) begin
        if (!m_wvalid && !err0 && !rst) viol++;
        else if (m_wvalid && m_wdata !== s_wdata) viol++;
      end
      if (m_wvalid && m_wstrb !== 4'hF) viol++;
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0; end
      if (s_bv && s_br) begin b_pend = 0; wr_idx++; end
      if (s_arv && s_arr) begin ar_log.push_back(s_araddr); r_pend = 1; r_wait = 0; end
      if (s_rv && s_rr) r_pend = 0;
      if (c == 0) err_first = err0;
      if (busy0) busy_cnt++;
      if (done0) begin done_cnt++; done_lat = c + 1; end
      if (done1) done1_cnt++;
      if (m_arvalid) arv_cnt++;
      if (rst_in_bctrl && !rst_used && m_bready && aw_log.size() == 2) begin
        #2 rst = 1'b1;
        #1 rst_snap = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy0, done0, err0, busy1};
        rst_c = c; rst_used = 1; b_pend = 0; r_pend = 0; aw_got = 0; w_got = 0;
      end
      // Drive slave outputs for the coming edge.
      wi = (wr_idx > 1) ? 1 : wr_idx;
      m_awready = m_awvalid && (aw_wait >= aw_lat[wi]);
      if (m_awvalid) aw_wait++;
      m_wready = m_wvalid && (w_wait >= w_lat[wi]);
      if (m_wvalid) w_wait++;
      m_bvalid = b_pend && (b_wait >= b_lat);
      m_bresp  = m_bvalid ? bresp_cfg[wi] : 2'b00;
      if (b_pend) b_wait++;
      m_arready = m_arvalid && !ar_never;
      m_rvalid  = r_pend && (r_wait >= r_lat);
      m_rdata   = m_rvalid ? rdata_cfg : 32'h0;
      m_rresp   = m_rvalid ? rresp_cfg : 2'b00;
      if (r_pend) r_wait++;
      {s_awv, s_awr, s_wv, s_wr} = {m_awvalid, m_awready, m_wvalid, m_wready};
      {s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = {m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready};
      s_awaddr = m_awaddr; s_wdata = m_wdata; s_araddr = m_araddr;
      if (!busy0 && !rst && c > 0) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin fin = 1; break; end
    end
    start = 1'b0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    if (!fin) seq_to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_valids got %b exp 000", {m_awvalid, m_wvalid, m_arvalid}); end
    n_chk++; if ({m_bready, m_rready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies got %b exp 00", {m_bready, m_rready}); end
    n_chk++; if ({busy0, done0, err0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy0, done0, err0}); end
    n_chk++; if (code0 !== 2'd0) begin n_fail++; $display("FAIL reset_err_code got %0d exp 0", code0); end
    n_chk++; if (m_awaddr !== 32'h0) begin n_fail++; $display("FAIL reset_awaddr got %h exp 0", m_awaddr); end
    n_chk++; if (m_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got %h exp 0", m_araddr); end
    n_chk++; if (m_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", m_wdata); end
    n_chk++; if (m_wstrb !== 4'hF) begin n_fail++; $display("FAIL reset_wstrb got %h exp f", m_wstrb); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    default_cfg(); rdata_cfg = 32'h3;
    fill_model(32'h36, 32'h3);
    run_seq(32'h36, 32'h3);
    n_chk++; if (seq_to !== 1'b0) begin n_fail++; $display("FAIL zw_finish got timeout exp finish"); end
    n_chk++; if (aw_log.size() != exp_aw_q.size()) begin n_fail++; $display("FAIL zw_aw_count got %0d exp %0d", aw_log.size(), exp_aw_q.size()); end
    else foreach (exp_aw_q[i]) begin n_chk++; if (aw_log[i] !== exp_aw_q[i]) begin n_fail++; $display("FAIL zw_awaddr%0d got %h exp %h", i, aw_log[i], exp_aw_q[i]); end end
    n_chk++; if (w_log.size() != exp_w_q.size()) begin n_fail++; $display("FAIL zw_w_count got %0d exp %0d", w_log.size(), exp_w_q.size()); end
    else foreach (exp_w_q[i]) begin n_chk++; if (w_log[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL zw_wdata%0d got %h exp %h", i, w_log[i], exp_w_q[i]); end end
    n_chk++; if (ar_log.size() != 1 || ar_log[0] !== CTRL_A) begin n_fail++; $display("FAIL zw_ar got %0d beats exp 1 at %h", ar_log.size(), CTRL_A); end
    n_chk++; if (done_lat != 7) begin n_fail++; $display("FAIL zw_latency got %0d exp 7", done_lat); end
    n_chk++; if (busy_cnt != 6) begin n_fail++; $display("FAIL zw_busy_cycles got %0d exp 6", busy_cnt); end
    n_chk++; if (done_cnt != 1 || done1_cnt != 1) begin n_fail++; $display("FAIL zw_done got %0d/%0d exp 1/1", done_cnt, done1_cnt); end
    n_chk++; if (err0 !== 1'b0 || code0 !== 2'd0) begin n_fail++; $display("FAIL zw_err got %b/%0d exp 0/0", err0, code0); end
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL zw_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_handshake_order();
    logic [31:0] b, c;
    default_cfg();
    aw_lat = '{0, 2}; w_lat = '{3, 0};
    b = $urandom; c = $urandom; rdata_cfg = c;
    run_seq(b, c);
    n_chk++; if (aw_hold.size() != 2 || aw_hold[0] != 1 || aw_hold[1] != 3) begin n_fail++; $display("FAIL ho_aw_hold got %p exp 1,3", aw_hold); end
    n_chk++; if (w_hold.size() != 2 || w_hold[0] != 4 || w_hold[1] != 1) begin n_fail++; $display("FAIL ho_w_hold got %p exp 4,1", w_hold); end
    n_chk++; if (w_log.size() != 2 || w_log[0] !== b || w_log[1] !== c) begin n_fail++; $display("FAIL ho_wdata got %p exp %h,%h", w_log, b, c); end
    n_chk++; if (ar_log.size() != 1) begin n_fail++; $display("FAIL ho_ar_count got %0d exp 1", ar_log.size()); end
    n_chk++; if (done_cnt != 1 || err0 !== 1'b0) begin n_fail++; $display("FAIL ho_done got %0d err %b exp 1 err 0", done_cnt, err0); end
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL ho_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_bresp_err();
    default_cfg(); bresp_cfg[0] = 2'b10; rdata_cfg = 32'h5;
    run_seq(32'h1b, 32'h5);
    n_chk++; if (aw_log.size() != 1 || ar_log.size() != 0) begin n_fail++; $display("FAIL be_beats got aw %0d ar %0d exp 1 0", aw_log.size(), ar_log.size()); end
    n_chk++; if (err0 !== 1'b1 || code0 !== 2'd1) begin n_fail++; $display("FAIL be_err got %b/%0d exp 1/1", err0, code0); end
    n_chk++; if (err1 !== 1'b1 || code1 !== 2'd1) begin n_fail++; $display("FAIL be_err_m got %b/%0d exp 1/1", err1, code1); end
    n_chk++; if (done_cnt != 0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL be_done_busy got %0d/%b exp 0/0", done_cnt, busy0); end
  endtask

  task automatic test_readback_mask();
    default_cfg(); rdata_cfg = 32'h7;
    run_seq(32'h36, 32'h3);
    n_chk++; if (err0 !== 1'b1 || code0 !== 2'd2 || done_cnt != 0) begin n_fail++; $display("FAIL rb_full_mask got %b/%0d done %0d exp 1/2 done 0", err0, code0, done_cnt); end
    n_chk++; if (err1 !== 1'b0 || code1 !== 2'd0 || done1_cnt != 1) begin n_fail++; $display("FAIL rb_low_mask got %b/%0d done %0d exp 0/0 done 1", err1, code1, done1_cnt); end
  endtask

  task automatic test_timeout();
    default_cfg(); ar_never = 1'b1;
    run_seq(32'h36, 32'h3);
    n_chk++; if (arv_cnt != 16) begin n_fail++; $display("FAIL to_arvalid_cycles got %0d exp 16", arv_cnt); end
    n_chk++; if (err0 !== 1'b1 || code0 !== 2'd3 || code1 !== 2'd3) begin n_fail++; $display("FAIL to_code got %b/%0d/%0d exp 1/3/3", err0, code0, code1); end
    n_chk++; if (m_arvalid !== 1'b0 || done_cnt != 0) begin n_fail++; $display("FAIL to_abandon got arvalid %b done %0d exp 0 0", m_arvalid, done_cnt); end
    default_cfg(); rdata_cfg = 32'h3;
    run_seq(32'h36, 32'h3);
    n_chk++; if (err_first !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %b exp 0", err_first); end
    n_chk++; if (done_cnt != 1 || err0 !== 1'b0 || code0 !== 2'd0) begin n_fail++; $display("FAIL to_retry got done %0d err %b/%0d exp 1 0/0", done_cnt, err0, code0); end
  endtask

  task automatic test_reset_mid();
    default_cfg(); rst_in_bctrl = 1'b1; rdata_cfg = 32'h9;
    run_seq(32'h44, 32'h9);
    n_chk++; if (rst_snap !== 9'h0) begin n_fail++; $display("FAIL rm_outputs_in_reset got %b exp 000000000", rst_snap); end
    n_chk++; if (aw_log.size() != 2 || ar_log.size() != 0 || done_cnt != 0) begin n_fail++; $display("FAIL rm_no_more got aw %0d ar %0d done %0d exp 2 0 0", aw_log.size(), ar_log.size(), done_cnt); end
    n_chk++; if (busy0 !== 1'b0 || err0 !== 1'b0) begin n_fail++; $display("FAIL rm_idle got busy %b err %b exp 0 0", busy0, err0); end
    default_cfg(); rdata_cfg = 32'h9;
    run_seq(32'h44, 32'h9);
    n_chk++; if (done_cnt != 1 || ar_log.size() != 1) begin n_fail++; $display("FAIL rm_after_release got done %0d ar %0d exp 1 1", done_cnt, ar_log.size()); end
  endtask

  task automatic test_start_while_busy();
    default_cfg(); restart_at = 3; rdata_cfg = 32'h3;
    run_seq(32'h36, 32'h3);
    n_chk++; if (aw_log.size() != 2 || ar_log.size() != 1) begin n_fail++; $display("FAIL sb_beats got aw %0d ar %0d exp 2 1", aw_log.size(), ar_log.size()); end
    n_chk++; if (done_cnt != 1 || busy_cnt != 6) begin n_fail++; $display("FAIL sb_single got done %0d busy %0d exp 1 6", done_cnt, busy_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] b, c;
    logic [1:0]  ec0, ec1;
    for (int it = 0; it < 8; it++) begin
      default_cfg();
      aw_lat = '{$urandom_range(0, 4), $urandom_range(0, 4)};
      w_lat  = '{$urandom_range(0, 4), $urandom_range(0, 4)};
      b_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) bresp_cfg[$urandom_range(0, 1)] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) rresp_cfg = 2'($urandom_range(1, 3));
      b = $urandom; c = $urandom;
      rdata_cfg = ($urandom_range(0, 2) == 0) ? (c ^ (32'h1 << $urandom_range(0, 31))) : c;
      fill_model(b, c);
      ec0 = model_code(c, 32'hFFFF_FFFF); ec1 = model_code(c, MASK1);
      run_seq(b, c);
      n_chk++; if (aw_log.size() != exp_aw_q.size() || w_log.size() != exp_w_q.size() || ar_log.size() != exp_ar_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_beats got %0d/%0d/%0d exp %0d/%0d/%0d", it, aw_log.size(), w_log.size(), ar_log.size(), exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size());
      end else begin
        foreach (exp_aw_q[i]) begin n_chk++; if (aw_log[i] !== exp_aw_q[i] || w_log[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL rnd%0d_wr%0d got %h/%h exp %h/%h", it, i, aw_log[i], w_log[i], exp_aw_q[i], exp_w_q[i]); end end
      end
      n_chk++; if (code0 !== ec0 || err0 !== (ec0 != 2'd0) || done_cnt != ((ec0 == 2'd0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_result got %0d/%b/%0d exp code %0d", it, code0, err0, done_cnt, ec0); end
      n_chk++; if (code1 !== ec1 || done1_cnt != ((ec1 == 2'd0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_result_m got %0d/%0d exp code %0d", it, code1, done1_cnt, ec1); end
      n_chk++; if (viol != 0 || seq_to) begin n_fail++; $display("FAIL rnd%0d_protocol got %0d violations timeout %b exp 0 0", it, viol, seq_to); end
    end
  endtask

  initial begin
    default_cfg();
    test_reset();
    test_zero_wait();
    test_handshake_order();
    test_bresp_err();
    test_readback_mask();
    test_timeout();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
